// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences one instruction at a time between the EX/MEM
// register and a fixed-latency data memory. Drives the memory request for
// LATENCY cycles and then presents a one-cycle result to writeback.
module mem_access_ctrl #(
  parameter int LATENCY = 3,
  parameter int DEST_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_address,
  input  logic [31:0]       ex_write_data,
  input  logic              ex_memRead,
  input  logic              ex_memWrite,
  input  logic              ex_word,
  input  logic              ex_regWrite,
  input  logic [DEST_W-1:0] ex_dest,
  output logic [31:0]       address,
  output logic [31:0]       write_data,
  output logic              memRead,
  output logic              memWrite,
  output logic              word,
  input  logic [31:0]       read_data,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic [DEST_W-1:0] wb_dest,
  output logic              wb_regWrite,
  output logic              misaligned
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  localparam logic [4:0] CNT_INIT = 5'(LATENCY - 1);

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [31:0]         address_q, address_d;
  logic [31:0]         write_data_q, write_data_d;
  logic                memRead_q, memRead_d;
  logic                memWrite_q, memWrite_d;
  logic                word_q, word_d;
  logic                wb_valid_q, wb_valid_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic [DEST_W-1:0]   wb_dest_q, wb_dest_d;
  logic                wb_regWrite_q, wb_regWrite_d;
  logic                misaligned_q, misaligned_d;
  // Fields captured at acceptance and consumed when the access completes
  logic                load_q, load_d;
  logic                regwr_q, regwr_d;
  logic [DEST_W-1:0]   dest_q, dest_d;

  logic accept;
  logic is_mem;
  logic bad_align;

  assign ex_ready  = (state_q == IDLE) && !reset;
  assign accept    = ex_valid && ex_ready;
  assign is_mem    = ex_memRead || ex_memWrite;
  assign bad_align = ex_word && (ex_address[1:0] != 2'b00);

  // Next-state, request and result formation
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    address_d     = address_q;
    write_data_d  = write_data_q;
    memRead_d     = memRead_q;
    memWrite_d    = memWrite_q;
    word_d        = word_q;
    wb_valid_d    = 1'b0;
    wb_data_d     = wb_data_q;
    wb_dest_d     = wb_dest_q;
    wb_regWrite_d = 1'b0;
    misaligned_d  = 1'b0;
    load_d        = load_q;
    regwr_d       = regwr_q;
    dest_d        = dest_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            // ALU result passes straight through in one cycle
            wb_valid_d    = 1'b1;
            wb_data_d     = ex_address;
            wb_dest_d     = ex_dest;
            wb_regWrite_d = ex_regWrite;
          end else if (bad_align) begin
            // Misaligned word access: no memory request is issued
            misaligned_d  = 1'b1;
            wb_valid_d    = 1'b1;
            wb_data_d     = 32'd0;
            wb_dest_d     = ex_dest;
          end else begin
            // A read+write request is handled as a store only
            state_d      = ACCESS;
            cnt_d        = CNT_INIT;
            address_d    = ex_address;
            write_data_d = ex_write_data;
            word_d       = ex_word;
            memWrite_d   = ex_memWrite;
            memRead_d    = ex_memRead && !ex_memWrite;
            load_d       = ex_memRead && !ex_memWrite;
            regwr_d      = ex_regWrite;
            dest_d       = ex_dest;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == 5'd0) begin
          state_d    = IDLE;
          memRead_d  = 1'b0;
          memWrite_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_dest_d  = dest_q;
          if (load_q) begin
            wb_data_d     = word_q ? read_data : {24'd0, read_data[7:0]};
            wb_regWrite_d = regwr_q;
          end else begin
            wb_data_d     = 32'd0;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything and abandons any access
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 5'd0;
      address_q     <= 32'd0;
      write_data_q  <= 32'd0;
      memRead_q     <= 1'b0;
      memWrite_q    <= 1'b0;
      word_q        <= 1'b0;
      wb_valid_q    <= 1'b0;
      wb_data_q     <= 32'd0;
      wb_dest_q     <= '0;
      wb_regWrite_q <= 1'b0;
      misaligned_q  <= 1'b0;
      load_q        <= 1'b0;
      regwr_q       <= 1'b0;
      dest_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      address_q     <= address_d;
      write_data_q  <= write_data_d;
      memRead_q     <= memRead_d;
      memWrite_q    <= memWrite_d;
      word_q        <= word_d;
      wb_valid_q    <= wb_valid_d;
      wb_data_q     <= wb_data_d;
      wb_dest_q     <= wb_dest_d;
      wb_regWrite_q <= wb_regWrite_d;
      misaligned_q  <= misaligned_d;
      load_q        <= load_d;
      regwr_q       <= regwr_d;
      dest_q        <= dest_d;
    end
  end

  assign address     = address_q;
  assign write_data  = write_data_q;
  assign memRead     = memRead_q;
  assign memWrite    = memWrite_q;
  assign word        = word_q;
  assign wb_valid    = wb_valid_q;
  assign wb_data     = wb_data_q;
  assign wb_dest     = wb_dest_q;
  assign wb_regWrite = wb_regWrite_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: runs the same suite against a
// LATENCY=3 instance and a LATENCY=1 instance sharing one stimulus bus.
module tb_mem_access_ctrl;
  localparam int DEST_W = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              ex_valid, ex_memRead, ex_memWrite, ex_word, ex_regWrite;
  logic [31:0]       ex_address, ex_write_data, read_data;
  logic [DEST_W-1:0] ex_dest;

  logic              ready_a [2];
  logic [31:0]       address_a [2];
  logic [31:0]       write_data_a [2];
  logic              memRead_a [2];
  logic              memWrite_a [2];
  logic              word_a [2];
  logic              wb_valid_a [2];
  logic [31:0]       wb_data_a [2];
  logic [DEST_W-1:0] wb_dest_a [2];
  logic              wb_regWrite_a [2];
  logic              misaligned_a [2];

  // Instance 0 uses LATENCY=3, instance 1 uses LATENCY=1
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_access_ctrl #(.LATENCY(g == 0 ? 3 : 1), .DEST_W(DEST_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .ex_valid      (ex_valid),
      .ex_ready      (ready_a[g]),
      .ex_address    (ex_address),
      .ex_write_data (ex_write_data),
      .ex_memRead    (ex_memRead),
      .ex_memWrite   (ex_memWrite),
      .ex_word       (ex_word),
      .ex_regWrite   (ex_regWrite),
      .ex_dest       (ex_dest),
      .address       (address_a[g]),
      .write_data    (write_data_a[g]),
      .memRead       (memRead_a[g]),
      .memWrite      (memWrite_a[g]),
      .word          (word_a[g]),
      .read_data     (read_data),
      .wb_valid      (wb_valid_a[g]),
      .wb_data       (wb_data_a[g]),
      .wb_dest       (wb_dest_a[g]),
      .wb_regWrite   (wb_regWrite_a[g]),
      .misaligned    (misaligned_a[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;
  int sel;
  int lat;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (LATENCY=%0d, t=%0t): got 0x%08h, want 0x%08h", tag, lat, $time, act, exp);
    end
  endtask

  task automatic idle_bus();
    ex_valid = 1'b0; ex_memRead = 1'b0; ex_memWrite = 1'b0; ex_word = 1'b0;
    ex_regWrite = 1'b0; ex_address = 32'd0; ex_write_data = 32'd0; ex_dest = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_bus();
    @(negedge clk);
    #1 check("rst_ready_low", 32'(ready_a[sel]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_address", address_a[sel], 32'd0);
    check("rst_wdata", write_data_a[sel], 32'd0);
    check("rst_ctl", {27'd0, memRead_a[sel], memWrite_a[sel], word_a[sel],
                      wb_valid_a[sel], misaligned_a[sel]}, 32'd0);
    check("rst_wb_data", wb_data_a[sel], 32'd0);
    check("rst_wb_dest", 32'(wb_dest_a[sel]), 32'd0);
    check("rst_wb_rw", 32'(wb_regWrite_a[sel]), 32'd0);
    check("rst_ready_high", 32'(ready_a[sel]), 32'd1);
  endtask

  // Issues one legal memory op at the current negedge and follows it to writeback
  task automatic mem_op(input string tg, input logic rd, input logic wr, input logic wd,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [4:0] dest, input logic rw,
                        input logic [31:0] exp_data, input logic exp_rw);
    check({tg, "_ready_pre"}, 32'(ready_a[sel]), 32'd1);
    ex_valid = 1'b1; ex_memRead = rd; ex_memWrite = wr; ex_word = wd;
    ex_address = addr; ex_write_data = wdata; ex_dest = dest; ex_regWrite = rw;
    read_data = rdata;
    @(negedge clk);
    idle_bus();
    for (int i = 0; i < lat; i++) begin
      check({tg, "_memRead"}, 32'(memRead_a[sel]), 32'(rd & ~wr));
      check({tg, "_memWrite"}, 32'(memWrite_a[sel]), 32'(wr));
      check({tg, "_word"}, 32'(word_a[sel]), 32'(wd));
      check({tg, "_address"}, address_a[sel], addr);
      if (wr) check({tg, "_wdata"}, write_data_a[sel], wdata);
      check({tg, "_ready_busy"}, 32'(ready_a[sel]), 32'd0);
      check({tg, "_wbv_busy"}, 32'(wb_valid_a[sel]), 32'd0);
      @(negedge clk);
    end
    check({tg, "_wb_valid"}, 32'(wb_valid_a[sel]), 32'd1);
    check({tg, "_wb_data"}, wb_data_a[sel], exp_data);
    check({tg, "_wb_dest"}, 32'(wb_dest_a[sel]), 32'(dest));
    check({tg, "_wb_rw"}, 32'(wb_regWrite_a[sel]), 32'(exp_rw));
    check({tg, "_mem_off"}, {30'd0, memRead_a[sel], memWrite_a[sel]}, 32'd0);
    check({tg, "_ready_post"}, 32'(ready_a[sel]), 32'd1);
    @(negedge clk);
    check({tg, "_wbv_pulse"}, 32'(wb_valid_a[sel]), 32'd0);
    check({tg, "_wb_data_hold"}, wb_data_a[sel], exp_data);
  endtask

  task automatic run_suite();
    int rcyc;
    do_reset();
    @(negedge clk);
    mem_op("ldw", 1, 0, 1, 32'h4, 32'h0, 32'hDEADBEEF, 5'd7, 1, 32'hDEADBEEF, 1);
    mem_op("ldb", 1, 0, 0, 32'h5, 32'h0, 32'hFFFFFF9A, 5'd9, 1, 32'h0000009A, 1);
    mem_op("stw", 0, 1, 1, 32'h8, 32'h12345678, 32'hAAAA5555, 5'd4, 0, 32'h0, 0);
    mem_op("rdwr", 1, 1, 0, 32'h3, 32'h000000C3, 32'h11111111, 5'd5, 1, 32'h0, 0);

    // Misaligned word load
    ex_valid = 1'b1; ex_memRead = 1'b1; ex_word = 1'b1; ex_address = 32'h6;
    ex_regWrite = 1'b1; ex_dest = 5'd3;
    @(negedge clk);
    idle_bus();
    check("mis_flag", 32'(misaligned_a[sel]), 32'd1);
    check("mis_wbv", 32'(wb_valid_a[sel]), 32'd1);
    check("mis_rw", 32'(wb_regWrite_a[sel]), 32'd0);
    check("mis_data", wb_data_a[sel], 32'd0);
    check("mis_nomem", {30'd0, memRead_a[sel], memWrite_a[sel]}, 32'd0);
    check("mis_ready", 32'(ready_a[sel]), 32'd1);
    @(negedge clk);
    check("mis_pulse", {30'd0, misaligned_a[sel], wb_valid_a[sel]}, 32'd0);
    check("mis_nomem2", {30'd0, memRead_a[sel], memWrite_a[sel]}, 32'd0);

    // Three back-to-back ALU ops, then a load
    ex_valid = 1'b1; ex_regWrite = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      ex_address = 32'(k); ex_dest = 5'(10 + k);
      @(negedge clk);
      check("alu_wbv", 32'(wb_valid_a[sel]), 32'd1);
      check("alu_data", wb_data_a[sel], 32'(k));
      check("alu_dest", 32'(wb_dest_a[sel]), 32'(10 + k));
      check("alu_rw", 32'(wb_regWrite_a[sel]), 32'd1);
      check("alu_ready", 32'(ready_a[sel]), 32'd1);
    end
    mem_op("alu_ld", 1, 0, 1, 32'h20, 32'h0, 32'hCAFEF00D, 5'd2, 1, 32'hCAFEF00D, 1);

    // Reset during the access window of a load
    rcyc = (lat >= 2) ? 2 : 1;
    ex_valid = 1'b1; ex_memRead = 1'b1; ex_word = 1'b1; ex_address = 32'h40;
    ex_regWrite = 1'b1; ex_dest = 5'd6; read_data = 32'h55AA55AA;
    @(negedge clk);
    idle_bus();
    for (int i = 1; i <= rcyc; i++) begin
      check("rmid_memRead", 32'(memRead_a[sel]), 32'd1);
      if (i < rcyc) @(negedge clk);
    end
    reset = 1'b1;
    #1 check("rmid_ready_rst", 32'(ready_a[sel]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("rmid_memRead_off", 32'(memRead_a[sel]), 32'd0);
    check("rmid_no_wbv", 32'(wb_valid_a[sel]), 32'd0);
    check("rmid_addr_clr", address_a[sel], 32'd0);
    @(negedge clk);
    check("rmid_ready", 32'(ready_a[sel]), 32'd1);
    check("rmid_no_wbv2", 32'(wb_valid_a[sel]), 32'd0);
    check("rmid_memRead_off2", 32'(memRead_a[sel]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rmid_quiet", {30'd0, wb_valid_a[sel], memRead_a[sel]}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    read_data = 32'd0;
    idle_bus();
    sel = 0; lat = 3;
    run_suite();
    sel = 1; lat = 1;
    run_suite();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle sequencer between the EX/MEM pipeline register and the data memory stage. It accepts one instruction at a time and drives the memory's `address`, `write_data`, `memRead`, `memWrite` and `word` inputs for a fixed access window. It samples `read_data`, zero-extends byte loads and presents a one-cycle result to writeback. It also provides the back-pressure signal (`ex_ready`) that stalls the upstream pipeline while a memory access is in flight.

## Interface
- LATENCY, 3, cycles the memory needs a request held before `read_data` is valid; legal range 1..16
- DEST_W, 5, destination register index width
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  upstream presents an instruction
- ex_ready  out  1  block can accept; transfer happens when `ex_valid & ex_ready` at a rising edge
- ex_address  in  32  byte address, or ALU result for non-memory ops
- ex_write_data  in  32  store data
- ex_memRead  in  1  load
- ex_memWrite  in  1  store
- ex_word  in  1  1 = word access (LDW/STW), 0 = byte access (LDB/STB)
- ex_regWrite  in  1  instruction writes a register
- ex_dest  in  DEST_W  destination register
- address  out  32  to memory stage
- write_data  out  32  to memory stage
- memRead  out  1  to memory stage
- memWrite  out  1  to memory stage
- word  out  1  to memory stage
- read_data  in  32  from memory stage
- wb_valid  out  1  one-cycle result strobe to writeback
- wb_data  out  32  load data or pass-through ALU result
- wb_dest  out  DEST_W  destination register
- wb_regWrite  out  1  writeback enable qualified by wb_valid
- misaligned  out  1  one-cycle pulse: word access with `ex_address[1:0] != 0`

## Operation
- States are IDLE and ACCESS. A down-counter of width clog2(16)+1 = 5 bits tracks the access window.
- `ex_ready` = (state == IDLE) & !reset. The block captures every `ex_*` field on acceptance, so upstream need not hold them afterwards.
- Classification on acceptance in IDLE:
  - Non-memory op (`ex_memRead` = 0 and `ex_memWrite` = 0): stay in IDLE. Next cycle `wb_valid` = 1, `wb_data` = ex_address, `wb_regWrite` = ex_regWrite.
  - Both `ex_memRead` and `ex_memWrite` = 1: treat as a store only.
  - Misaligned word access: no memory request is issued and the block stays in IDLE. Next cycle `misaligned` = 1, `wb_valid` = 1, `wb_regWrite` = 0, `wb_data` = 0.
  - Legal load or store: go to ACCESS with counter = LATENCY-1.
- In ACCESS:
  - Memory ports are driven from the captured fields: `memRead`/`memWrite` per op, `word` = captured `ex_word`.
  - The counter decrements each cycle. On the edge where the counter is 0, return to IDLE and register the result.
- Result formation:
  - Load: `wb_data` = read_data for a word access, {24'b0, read_data[7:0]} for a byte access. `wb_regWrite` = captured regWrite.
  - Store: `wb_data` = 0, `wb_regWrite` = 0.
- Outside ACCESS, `memRead` = `memWrite` = 0. `address`, `write_data` and `word` hold their last driven values.

## Timing
- Acceptance edge at the end of cycle T. Memory ports are asserted during cycles T+1 .. T+LATENCY inclusive. `read_data` is sampled at the edge ending cycle T+LATENCY.
- Memory op: `wb_valid` is high for exactly cycle T+LATENCY+1. `ex_ready` is low during T+1 .. T+LATENCY and high again in T+LATENCY+1, so back-to-back memory ops issue every LATENCY+1 cycles.
- Non-memory and misaligned ops: `wb_valid` (and `misaligned` if applicable) in cycle T+1. `ex_ready` stays high, giving one op per cycle.
- LATENCY = 1: ports asserted for the single cycle T+1.
- `wb_valid`, `misaligned`, `wb_regWrite` are single-cycle pulses. `wb_data` and `wb_dest` hold until the next result.
- Reset:
  - While asserted, `ex_ready` = 0.
  - At the reset edge: state goes to IDLE, counter = 0, and every registered output goes to 0 (`address`, `write_data`, `memRead`, `memWrite`, `word`, `wb_valid`, `wb_data`, `wb_dest`, `wb_regWrite`, `misaligned`).
  - Reset mid-ACCESS abandons the op: `memRead`/`memWrite` are low the cycle after the reset edge, and no `wb_valid` is produced. A store may already have been committed by the level-sensitive memory; this is accepted.
- `ex_valid` while `ex_ready` = 0 is ignored; upstream must hold the instruction.

## Test plan
- Reset, then issue a word load: addr 0x4, memory returns 0xDEADBEEF, LATENCY = 3, dest 7. Required: memRead high for exactly 3 cycles; `wb_valid` 4 cycles after acceptance with `wb_data` 0xDEADBEEF, `wb_dest` 7, `wb_regWrite` 1.
- Byte load: addr 0x5, read_data 0xFFFFFF9A. Required: `wb_data` = 0x0000009A.
- Word store: addr 0x8, data 0x12345678. Required: `memWrite`/`word` high for 3 cycles with `write_data` 0x12345678; `wb_valid` pulse with `wb_regWrite` 0; `ex_ready` low during the window.
- Word access at addr 0x6. Required: no memRead/memWrite; next cycle `misaligned` = 1, `wb_valid` = 1, `wb_regWrite` = 0.
- Three consecutive ALU ops (results 1, 2, 3) followed by a load. Required: `wb_valid` on 3 consecutive cycles with data 1, 2, 3; the load is accepted on the 4th edge; `ex_ready` drops for LATENCY cycles.
- Reset asserted in the 2nd access cycle of a load. Required: memRead low the next cycle, no `wb_valid`, `ex_ready` = 1 the cycle after reset deasserts. Repeat the full suite with LATENCY = 1.
